// File: rtl/imm_gen_pipe_if.sv
// Bus bundle for imm_gen_pipe: instruction beats in, immediates out, plus flush.
// Handshake: a beat moves on a rising edge where valid & ready are both high.
// The sender holds valid and its data steady until that edge.
// The receiver may raise or drop ready at any time.
`timescale 1ns/1ps

interface imm_gen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_inst;
   logic [2:0]       in_sel;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [TAG_W-1:0] out_tag;
   logic             out_illegal;

   modport master (
      output flush, in_valid, in_inst, in_sel, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_tag, out_illegal
   );

   modport slave (
      input  flush, in_valid, in_inst, in_sel, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_tag, out_illegal
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator.
// The immediate is decoded at the input and held in a main register M backed by a skid register K.
`timescale 1ns/1ps

module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input logic          clk,
   input logic          rst_n,
   imm_gen_pipe_if.slave bus
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end

   localparam logic [2:0] SEL_I  = 3'd0;
   localparam logic [2:0] SEL_S  = 3'd1;
   localparam logic [2:0] SEL_B  = 3'd2;
   localparam logic [2:0] SEL_U  = 3'd3;
   localparam logic [2:0] SEL_J  = 3'd4;
   localparam logic [2:0] SEL_Z  = 3'd5;
   localparam logic [2:0] SEL_SH = 3'd6;

   logic [31:0] inst;
   logic        s;
   logic [63:0] imm_full;
   logic        new_ill;
   logic [XLEN-1:0] new_imm;

   assign inst = bus.in_inst;
   assign s    = inst[31];

   // Decode at full 64-bit width, then truncate; avoids zero-width replications for XLEN=32.
   always_comb begin
      imm_full = 64'd0;
      new_ill  = 1'b0;
      case (bus.in_sel)
         SEL_I:  imm_full = {{52{s}}, inst[31:20]};
         SEL_S:  imm_full = {{52{s}}, inst[31:25], inst[11:7]};
         SEL_B:  imm_full = {{51{s}}, s, inst[7], inst[30:25], inst[11:8], 1'b0};
         SEL_U:  imm_full = {{32{s}}, inst[31:12], 12'd0};
         SEL_J:  imm_full = {{43{s}}, s, inst[19:12], inst[20], inst[30:21], 1'b0};
         SEL_Z:  imm_full = {59'd0, inst[19:15]};
         SEL_SH: imm_full = (XLEN == 64) ? {58'd0, inst[25:20]} : {59'd0, inst[24:20]};
         default: begin
            imm_full = 64'd0;
            new_ill  = 1'b1;
         end
      endcase
   end

   assign new_imm = imm_full[XLEN-1:0];

   logic unused_bits;
   assign unused_bits = ^{inst[6:0], imm_full};

   logic             m_valid_q, m_valid_d;
   logic [XLEN-1:0]  m_imm_q,   m_imm_d;
   logic [TAG_W-1:0] m_tag_q,   m_tag_d;
   logic             m_ill_q,   m_ill_d;
   logic             k_valid_q, k_valid_d;
   logic [XLEN-1:0]  k_imm_q,   k_imm_d;
   logic [TAG_W-1:0] k_tag_q,   k_tag_d;
   logic             k_ill_q,   k_ill_d;

   logic push;
   logic pop;

   // in_ready depends only on registered state, so there is no combinational path from out_ready.
   assign push = bus.in_valid & ~k_valid_q;
   assign pop  = m_valid_q & bus.out_ready;

   always_comb begin
      m_valid_d = m_valid_q;
      m_imm_d   = m_imm_q;
      m_tag_d   = m_tag_q;
      m_ill_d   = m_ill_q;
      k_valid_d = k_valid_q;
      k_imm_d   = k_imm_q;
      k_tag_d   = k_tag_q;
      k_ill_d   = k_ill_q;
      if (bus.flush) begin
         m_valid_d = 1'b0;
         k_valid_d = 1'b0;
      end else if (!m_valid_q || pop) begin
         if (k_valid_q) begin
            m_valid_d = 1'b1;
            m_imm_d   = k_imm_q;
            m_tag_d   = k_tag_q;
            m_ill_d   = k_ill_q;
            k_valid_d = push;
            if (push) begin
               k_imm_d = new_imm;
               k_tag_d = bus.in_tag;
               k_ill_d = new_ill;
            end
         end else begin
            m_valid_d = push;
            if (push) begin
               m_imm_d = new_imm;
               m_tag_d = bus.in_tag;
               m_ill_d = new_ill;
            end
         end
      end else if (push) begin
         k_valid_d = 1'b1;
         k_imm_d   = new_imm;
         k_tag_d   = bus.in_tag;
         k_ill_d   = new_ill;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q <= 1'b0;
         m_imm_q   <= '0;
         m_tag_q   <= '0;
         m_ill_q   <= 1'b0;
         k_valid_q <= 1'b0;
         k_imm_q   <= '0;
         k_tag_q   <= '0;
         k_ill_q   <= 1'b0;
      end else begin
         m_valid_q <= m_valid_d;
         m_imm_q   <= m_imm_d;
         m_tag_q   <= m_tag_d;
         m_ill_q   <= m_ill_d;
         k_valid_q <= k_valid_d;
         k_imm_q   <= k_imm_d;
         k_tag_q   <= k_tag_d;
         k_ill_q   <= k_ill_d;
      end
   end

   assign bus.in_ready    = ~k_valid_q;
   assign bus.out_valid   = m_valid_q;
   assign bus.out_imm     = m_imm_q;
   assign bus.out_tag     = m_tag_q;
   assign bus.out_illegal = m_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed and randomized checks of imm_gen_pipe at XLEN=32 and XLEN=64.
`timescale 1ns/1ps

module tb_imm_gen_pipe;

   localparam int EW = 65;
   localparam int N_RAND = 10000;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_fail = 0;
   logic [EW-1:0] exp_q[$];

   always #5 clk = ~clk;

   imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
   imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

   imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
   imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference decode built from signed shifts and sign-extending assignments.
   function automatic logic [32:0] ref_imm32(input logic [31:0] inst, input logic [2:0] sel);
      logic signed [31:0] si;
      logic signed [12:0] b13;
      logic signed [20:0] j21;
      logic signed [31:0] r;
      logic ill;
      si  = inst;
      ill = 1'b0;
      r   = 32'sd0;
      b13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      j21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      case (sel)
         3'd0: r = si >>> 20;
         3'd1: r = ((si >>> 25) <<< 5) | $signed({27'd0, inst[11:7]});
         3'd2: r = b13;
         3'd3: r = $signed(inst & 32'hFFFFF000);
         3'd4: r = j21;
         3'd5: r = $signed({27'd0, inst[19:15]});
         3'd6: r = $signed({27'd0, inst[24:20]});
         default: ill = 1'b1;
      endcase
      return {ill, r};
   endfunction

   task automatic init_inputs();
      bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.in_inst = '0;
      bus32.in_sel = '0;  bus32.in_tag = '0;     bus32.out_ready = 1'b1;
      bus64.flush = 1'b0; bus64.in_valid = 1'b0; bus64.in_inst = '0;
      bus64.in_sel = '0;  bus64.in_tag = '0;     bus64.out_ready = 1'b1;
   endtask

   task automatic idle(input int n);
      bus32.in_valid = 1'b0;
      bus32.out_ready = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic drive32(input logic [31:0] inst, input logic [2:0] sel, input logic [31:0] tag,
                          output logic v, output logic [31:0] imm, output logic [31:0] otag,
                          output logic ill);
      bus32.out_ready = 1'b1;
      bus32.in_inst   = inst;
      bus32.in_sel    = sel;
      bus32.in_tag    = tag;
      bus32.in_valid  = 1'b1;
      @(negedge clk);
      bus32.in_valid = 1'b0;
      v    = bus32.out_valid;
      imm  = bus32.out_imm;
      otag = bus32.out_tag;
      ill  = bus32.out_illegal;
   endtask

   task automatic drive64(input logic [31:0] inst, input logic [2:0] sel, input logic [31:0] tag,
                          output logic v, output logic [63:0] imm, output logic [31:0] otag,
                          output logic ill);
      bus64.out_ready = 1'b1;
      bus64.in_inst   = inst;
      bus64.in_sel    = sel;
      bus64.in_tag    = tag;
      bus64.in_valid  = 1'b1;
      @(negedge clk);
      bus64.in_valid = 1'b0;
      v    = bus64.out_valid;
      imm  = bus64.out_imm;
      otag = bus64.out_tag;
      ill  = bus64.out_illegal;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_cmp++;
      if ({bus32.out_valid, bus32.in_ready, bus64.out_valid, bus64.in_ready} !== 4'b0101) begin
         n_fail++;
         $display("FAIL reset_during: got v32=%b r32=%b v64=%b r64=%b, need 0 1 0 1",
                  bus32.out_valid, bus32.in_ready, bus64.out_valid, bus64.in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({bus32.out_valid, bus32.in_ready, bus32.out_illegal} !== 3'b010 ||
          bus32.out_imm !== 32'd0 || bus32.out_tag !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_after: got v=%b r=%b ill=%b imm=%h tag=%h, need 0 1 0 0 0",
                  bus32.out_valid, bus32.in_ready, bus32.out_illegal, bus32.out_imm, bus32.out_tag);
      end
      n_cmp++;
      if (bus64.out_imm !== 64'd0 || bus64.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_after64: got v=%b imm=%h, need 0 0", bus64.out_valid, bus64.out_imm);
      end
   endtask

   task automatic test_formats32();
      logic [31:0] t_inst [12];
      logic [2:0]  t_sel  [12];
      logic [31:0] t_exp  [12];
      logic        v, ill;
      logic [31:0] imm, otag;
      t_inst[0]  = 32'hFFF00093; t_sel[0]  = 3'd0; t_exp[0]  = 32'hFFFFFFFF;
      t_inst[1]  = 32'hFE512E23; t_sel[1]  = 3'd1; t_exp[1]  = 32'hFFFFFFFC;
      t_inst[2]  = 32'h80000063; t_sel[2]  = 3'd2; t_exp[2]  = 32'hFFFFF000;
      t_inst[3]  = 32'h12345037; t_sel[3]  = 3'd3; t_exp[3]  = 32'h12345000;
      t_inst[4]  = 32'h001000EF; t_sel[4]  = 3'd4; t_exp[4]  = 32'h00000800;
      t_inst[5]  = 32'h000F8073; t_sel[5]  = 3'd5; t_exp[5]  = 32'h0000001F;
      t_inst[6]  = 32'h03F00013; t_sel[6]  = 3'd6; t_exp[6]  = 32'h0000001F;
      t_inst[7]  = 32'hFFFFFFFF; t_sel[7]  = 3'd7; t_exp[7]  = 32'h00000000;
      t_inst[8]  = 32'h7FF00093; t_sel[8]  = 3'd0; t_exp[8]  = 32'h000007FF;
      t_inst[9]  = 32'h800000EF; t_sel[9]  = 3'd4; t_exp[9]  = 32'hFFF00000;
      t_inst[10] = 32'h00000F80; t_sel[10] = 3'd1; t_exp[10] = 32'h0000001F;
      t_inst[11] = 32'h7E000FE3; t_sel[11] = 3'd2; t_exp[11] = 32'h00000FFE;
      for (int i = 0; i < 12; i++) begin
         drive32(t_inst[i], t_sel[i], 32'h100 + i, v, imm, otag, ill);
         n_cmp++;
         if (v !== 1'b1 || imm !== t_exp[i] || otag !== 32'h100 + i || ill !== (t_sel[i] == 3'd7)) begin
            n_fail++;
            $display("FAIL fmt32[%0d]: got v=%b imm=%h tag=%h ill=%b, need v=1 imm=%h tag=%h ill=%b",
                     i, v, imm, otag, ill, t_exp[i], 32'h100 + i, t_sel[i] == 3'd7);
         end
      end
      idle(2);
   endtask

   task automatic test_formats64();
      logic [31:0] t_inst [6];
      logic [2:0]  t_sel  [6];
      logic [63:0] t_exp  [6];
      logic        v, ill;
      logic [63:0] imm;
      logic [31:0] otag;
      t_inst[0] = 32'hFFF00093; t_sel[0] = 3'd0; t_exp[0] = 64'hFFFFFFFFFFFFFFFF;
      t_inst[1] = 32'h80000037; t_sel[1] = 3'd3; t_exp[1] = 64'hFFFFFFFF80000000;
      t_inst[2] = 32'h03F00013; t_sel[2] = 3'd6; t_exp[2] = 64'h000000000000003F;
      t_inst[3] = 32'h12345037; t_sel[3] = 3'd3; t_exp[3] = 64'h0000000012345000;
      t_inst[4] = 32'h80000063; t_sel[4] = 3'd2; t_exp[4] = 64'hFFFFFFFFFFFFF000;
      t_inst[5] = 32'h000F8073; t_sel[5] = 3'd5; t_exp[5] = 64'h000000000000001F;
      for (int i = 0; i < 6; i++) begin
         drive64(t_inst[i], t_sel[i], 32'h200 + i, v, imm, otag, ill);
         n_cmp++;
         if (v !== 1'b1 || imm !== t_exp[i] || otag !== 32'h200 + i || ill !== 1'b0) begin
            n_fail++;
            $display("FAIL fmt64[%0d]: got v=%b imm=%h tag=%h ill=%b, need v=1 imm=%h tag=%h ill=0",
                     i, v, imm, otag, ill, t_exp[i], 32'h200 + i);
         end
      end
      bus64.in_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int          n_pop;
      int          pop_cyc [3];
      logic [31:0] pop_tag [3];
      logic        accepted;
      logic        popped;
      logic [31:0] cur_tag;
      n_pop = 0;
      bus32.out_ready = 1'b0;
      bus32.in_inst   = 32'hFFF00093;
      bus32.in_sel    = 3'd0;
      bus32.in_tag    = 32'hA;
      bus32.in_valid  = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 32'hA || bus32.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_first: got v=%b tag=%h rdy=%b, need 1 a 1",
                  bus32.out_valid, bus32.out_tag, bus32.in_ready);
      end
      bus32.in_tag = 32'hB;
      @(negedge clk);
      bus32.in_tag = 32'hC;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus32.in_ready !== 1'b0 || bus32.out_valid !== 1'b1 || bus32.out_tag !== 32'hA) begin
         n_fail++;
         $display("FAIL bp_full: got rdy=%b v=%b tag=%h, need 0 1 a",
                  bus32.in_ready, bus32.out_valid, bus32.out_tag);
      end
      bus32.out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         accepted = bus32.in_valid & bus32.in_ready;
         popped   = bus32.out_valid & bus32.out_ready;
         cur_tag  = bus32.out_tag;
         if (popped) begin
            if (n_pop < 3) begin
               pop_cyc[n_pop] = c;
               pop_tag[n_pop] = cur_tag;
            end
            n_pop++;
         end
         @(negedge clk);
         if (accepted) bus32.in_valid = 1'b0;
      end
      n_cmp++;
      if (n_pop !== 3) begin
         n_fail++;
         $display("FAIL bp_count: got %0d beats out, need 3", n_pop);
      end else begin
         n_cmp++;
         if ({pop_tag[0], pop_tag[1], pop_tag[2]} !== {32'hA, 32'hB, 32'hC} ||
             pop_cyc[0] !== 0 || pop_cyc[1] !== 1 || pop_cyc[2] !== 2) begin
            n_fail++;
            $display("FAIL bp_order: got tags %h %h %h at cycles %0d %0d %0d, need a b c at 0 1 2",
                     pop_tag[0], pop_tag[1], pop_tag[2], pop_cyc[0], pop_cyc[1], pop_cyc[2]);
         end
      end
      idle(2);
   endtask

   task automatic test_random();
      int           sent, recv, cycles;
      logic         hold, prev_stall;
      logic [EW:0]  prev_snap;
      logic [EW-1:0] exp_e, got_e;
      logic         push, pop;
      logic [32:0]  r;
      sent = 0; recv = 0; cycles = 0;
      hold = 1'b0; prev_stall = 1'b0; prev_snap = '0;
      while (recv < N_RAND && cycles < 60000) begin
         if (prev_stall) begin
            n_cmp++;
            if ({bus32.out_valid, bus32.out_illegal, bus32.out_imm, bus32.out_tag} !== prev_snap) begin
               n_fail++;
               $display("FAIL rand_stable: got %h, need %h", {bus32.out_valid, bus32.out_illegal,
                        bus32.out_imm, bus32.out_tag}, prev_snap);
            end
         end
         if (!hold) begin
            if (sent < N_RAND && $urandom_range(99) < 70) begin
               bus32.in_inst  = $urandom;
               bus32.in_sel   = 3'($urandom_range(7));
               bus32.in_tag   = $urandom;
               bus32.in_valid = 1'b1;
            end else begin
               bus32.in_valid = 1'b0;
            end
         end
         bus32.out_ready = (sent >= N_RAND) ? 1'b1 : ($urandom_range(99) < 60);
         push = bus32.in_valid & bus32.in_ready;
         pop  = bus32.out_valid & bus32.out_ready;
         if (pop) begin
            got_e = {bus32.out_illegal, bus32.out_imm, bus32.out_tag};
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rand_extra: got beat %h with nothing expected", got_e);
            end else begin
               exp_e = exp_q.pop_front();
               if (got_e !== exp_e) begin
                  n_fail++;
                  $display("FAIL rand_beat[%0d]: got %h, need %h", recv, got_e, exp_e);
               end
            end
            recv++;
         end
         if (push) begin
            r = ref_imm32(bus32.in_inst, bus32.in_sel);
            exp_q.push_back({r, bus32.in_tag});
            sent++;
         end
         hold       = bus32.in_valid & ~bus32.in_ready;
         prev_stall = bus32.out_valid & ~bus32.out_ready;
         prev_snap  = {bus32.out_valid, bus32.out_illegal, bus32.out_imm, bus32.out_tag};
         @(negedge clk);
         cycles++;
      end
      n_cmp++;
      if (recv !== N_RAND || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL rand_done: got %0d beats out, %0d left over after %0d cycles, need %0d and 0",
                  recv, exp_q.size(), cycles, N_RAND);
      end
      exp_q.delete();
      idle(2);
   endtask

   task automatic test_flush();
      logic        v, ill, seen;
      logic [31:0] imm, otag;
      bus32.out_ready = 1'b0;
      bus32.in_inst   = 32'hFFF00093;
      bus32.in_sel    = 3'd0;
      bus32.in_tag    = 32'h51;
      bus32.in_valid  = 1'b1;
      @(negedge clk);
      bus32.in_tag = 32'h52;
      @(negedge clk);
      bus32.in_tag = 32'h53;
      bus32.flush  = 1'b1;
      @(negedge clk);
      bus32.flush = 1'b0;
      bus32.in_valid = 1'b0;
      n_cmp++;
      if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_two: got v=%b rdy=%b, need 0 1", bus32.out_valid, bus32.in_ready);
      end
      bus32.out_ready = 1'b1;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         seen = seen | bus32.out_valid;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_stale: got out_valid=%b after flush, need 0", seen);
      end
      bus32.out_ready = 1'b0;
      bus32.in_tag    = 32'h54;
      bus32.in_valid  = 1'b1;
      @(negedge clk);
      bus32.in_tag = 32'h55;
      bus32.flush  = 1'b1;
      @(negedge clk);
      bus32.flush    = 1'b0;
      bus32.in_valid = 1'b0;
      n_cmp++;
      if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_push: got v=%b rdy=%b, need 0 1", bus32.out_valid, bus32.in_ready);
      end
      bus32.out_ready = 1'b1;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         seen = seen | bus32.out_valid;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_push_stale: got out_valid=%b, need 0", seen);
      end
      drive32(32'h000F8073, 3'd5, 32'hD, v, imm, otag, ill);
      n_cmp++;
      if (v !== 1'b1 || imm !== 32'h1F || otag !== 32'hD || ill !== 1'b0) begin
         n_fail++;
         $display("FAIL after_flush: got v=%b imm=%h tag=%h ill=%b, need 1 1f d 0", v, imm, otag, ill);
      end
      idle(2);
   endtask

   task automatic test_reset_mid();
      logic        v, ill, seen;
      logic [31:0] imm, otag;
      bus32.out_ready = 1'b0;
      bus32.in_inst   = 32'h12345037;
      bus32.in_sel    = 3'd3;
      bus32.in_tag    = 32'h61;
      bus32.in_valid  = 1'b1;
      @(negedge clk);
      bus32.in_tag = 32'h62;
      @(negedge clk);
      bus32.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 ||
          bus32.out_imm !== 32'd0 || bus32.out_tag !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_async: got v=%b rdy=%b imm=%h tag=%h, need 0 1 0 0",
                  bus32.out_valid, bus32.in_ready, bus32.out_imm, bus32.out_tag);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus32.out_ready = 1'b1;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         seen = seen | bus32.out_valid;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_stale: got out_valid=%b after reset, need 0", seen);
      end
      drive32(32'h001000EF, 3'd4, 32'hE, v, imm, otag, ill);
      n_cmp++;
      if (v !== 1'b1 || imm !== 32'h800 || otag !== 32'hE || ill !== 1'b0) begin
         n_fail++;
         $display("FAIL after_rst: got v=%b imm=%h tag=%h ill=%b, need 1 800 e 0", v, imm, otag, ill);
      end
      idle(2);
   endtask

   initial begin
      init_inputs();
      test_reset();
      test_formats32();
      test_formats64();
      test_back_to_back();
      test_random();
      test_flush();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
